// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the instruction-fetch sequencer
// Purpose: address/instruction widths, sequencer state encoding, prefetch entry
//          layout and the fetch-address legality check.
package fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic {RUN, STOP} fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Word aligned and the whole word inside the ROM. The sum is done one bit
  // wider than the address so addresses near 2^64 cannot wrap into range.
  function automatic logic is_legal_addr(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W:0]   mem_bytes);
    logic [ADDR_W:0] last_byte;
    last_byte = {1'b0, addr} + 65'd3;
    return (addr[1:0] == 2'b00) && (last_byte < mem_bytes);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO holding fetched words with their PCs
// Purpose: circular buffer with read/write pointers and an occupancy count.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push, wdata  : enqueue wdata this cycle (caller guarantees space or pop)
//   pop          : dequeue head this cycle (caller guarantees count != 0)
//   flush        : discard all entries; wins over push and pop
//   count        : number of valid entries (0..DEPTH)
//   head         : oldest entry; stale when count == 0
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // Storage is cleared so the head reads as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // When full with a simultaneous pop, wr_ptr equals rd_ptr: the slot
      // being written is the one leaving this cycle, so nothing is lost.
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch controller for the combinational ROM
// Purpose: owns the fetch PC, captures ROM words into a prefetch FIFO, hands
//          them to decode over valid/ready, takes branch redirects and flags
//          illegal fetch addresses with a sticky fault.
// Ports:
//   clk, reset_n               : clock, asynchronous active-low reset
//   imem_addr / imem_instr     : ROM byte address (fetch PC) and returned word
//   out_valid/out_ready        : decode handshake for the FIFO head
//   out_instr/out_pc           : head instruction and its byte address
//   redirect_valid/redirect_pc : flush and refetch from a new target
//   fault/fault_pc             : sticky illegal-address flag and its address
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              MEM_BYTES = 1024,
  parameter logic [63:0]     RESET_PC  = 64'h0,
  parameter int              DEPTH     = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [63:0]        imem_addr,
  input  logic [31:0]        imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [63:0]        out_pc,
  input  logic               redirect_valid,
  input  logic [63:0]        redirect_pc,
  output logic               fault,
  output logic [63:0]        fault_pc
);

  localparam int              CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [63:0]       fetch_pc, pc_d;
  logic              fault_q, fault_d;
  logic [63:0]       fault_pc_q, fault_pc_d;
  logic              push, pop, flush;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   ('{instr: imem_instr, pc: fetch_pc}),
    .count   (count),
    .head    (head)
  );

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      fetch_pc   <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc   <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  always_comb begin
    // Decode may consume the head in any state; a redirect flush discards it.
    pop        = out_valid & out_ready;
    push       = 1'b0;
    flush      = 1'b0;
    state_d    = state_q;
    pc_d       = fetch_pc;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;

    if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = redirect_pc;
      if (is_legal_addr(redirect_pc, MEM_LIMIT)) begin
        state_d = RUN;
        fault_d = 1'b0;
      end else begin
        state_d    = STOP;
        fault_d    = 1'b1;
        fault_pc_d = redirect_pc;
      end
    end else if (state_q == RUN) begin
      if (is_legal_addr(fetch_pc, MEM_LIMIT)) begin
        push = (count < DEPTH_C) | pop;
        if (push) begin
          pc_d = fetch_pc + 64'd4;
        end
      end else begin
        state_d    = STOP;
        fault_d    = 1'b1;
        fault_pc_d = fetch_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  localparam int MEM_BYTES = 1024;
  localparam int DEPTH     = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fault;
  logic [63:0] fault_pc;

  int total = 0;
  int bad   = 0;

  logic [31:0] rom [256];
  assign imem_instr = rom[imem_addr[9:2]];

  always #5 clk = ~clk;

  fetch_sequencer #(.MEM_BYTES(MEM_BYTES), .RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  // Reference model: the words decode should see, in order, plus the next
  // address to be fetched and the fault flag.
  logic [63:0] q[$];
  logic [63:0] m_nf;
  bit          m_fault;
  logic [63:0] m_fpc;

  function automatic bit m_legal(input logic [63:0] a);
    return (a % 4 == 0) && (a <= 64'(MEM_BYTES - 4));
  endfunction

  task automatic model_reset();
    q.delete();
    m_nf    = 64'h0;
    m_fault = 0;
    m_fpc   = 64'h0;
  endtask

  // One clock with the current inputs; model advanced at the edge; returns at negedge.
  task automatic tick();
    int sz;
    bit pop;
    @(posedge clk);
    if (redirect_valid) begin
      q.delete();
      m_nf = redirect_pc;
      if (m_legal(redirect_pc)) m_fault = 0;
      else begin
        m_fault = 1;
        m_fpc   = redirect_pc;
      end
    end else begin
      sz  = q.size();
      pop = (sz > 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (!m_fault) begin
        if (m_legal(m_nf)) begin
          if (sz < DEPTH || pop) begin
            q.push_back(m_nf);
            m_nf = m_nf + 64'd4;
          end
        end else begin
          m_fault = 1;
          m_fpc   = m_nf;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_pc !== 64'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    total++; if (fault !== 1'b0 || fault_pc !== 64'h0) begin bad++; $display("FAIL reset_fault: got %b/%h want 0/0", fault, fault_pc); end
    total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== rom[0]) begin
      bad++; $display("FAIL first_word: got v=%b pc=%h i=%h want 1/0/%h", out_valid, out_pc, out_instr, rom[0]);
    end
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_pc !== 64'(4 * k) || out_instr !== rom[k]) begin
        bad++; $display("FAIL stream[%0d]: got v=%b pc=%h i=%h want 1/%h/%h", k, out_valid, out_pc, out_instr, 4 * k, rom[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    apply_reset();
    repeat (5) tick();
    total++; if (imem_addr !== 64'd8) begin bad++; $display("FAIL bp_fetch_pc: got %h want 8", imem_addr); end
    total++; if (out_valid !== 1'b1 || out_pc !== 64'h0) begin bad++; $display("FAIL bp_hold: got v=%b pc=%h want 1/0", out_valid, out_pc); end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_pc !== 64'(4 * k) || out_instr !== rom[k]) begin
        bad++; $display("FAIL bp_drain[%0d]: got v=%b pc=%h want 1/%h", k, out_valid, out_pc, 4 * k);
      end
    end
  endtask

  task automatic test_redirect_full();
    out_ready = 1'b0;
    redirect(64'h10);
    repeat (3) tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 64'h10 || imem_addr !== 64'h18) begin
      bad++; $display("FAIL rf_full: got v=%b pc=%h addr=%h want 1/10/18", out_valid, out_pc, imem_addr);
    end
    out_ready = 1'b1;
    redirect(64'h40);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_bubble: got %b want 0", out_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_pc !== 64'h40 + 64'(4 * k) || out_instr !== rom[16 + k]) begin
        bad++; $display("FAIL rf_target[%0d]: got v=%b pc=%h want 1/%h", k, out_valid, out_pc, 64'h40 + 64'(4 * k));
      end
    end
  endtask

  task automatic test_end_of_mem();
    out_ready = 1'b1;
    redirect(64'd1000);
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_pc !== 64'd1000 + 64'(4 * k) || out_instr !== rom[250 + k]) begin
        bad++; $display("FAIL eom_word[%0d]: got v=%b pc=%h want 1/%0d", k, out_valid, out_pc, 1000 + 4 * k);
      end
    end
    tick();
    total++; if (fault !== 1'b1 || fault_pc !== 64'd1024) begin bad++; $display("FAIL eom_fault: got %b/%h want 1/400", fault, fault_pc); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (out_valid !== 1'b0 || fault !== 1'b1) begin bad++; $display("FAIL eom_stopped[%0d]: got v=%b f=%b want 0/1", k, out_valid, fault); end
    end
    redirect(64'h0);
    total++; if (fault !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL eom_clear: got f=%b v=%b want 0/0", fault, out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 64'h0) begin bad++; $display("FAIL eom_resume: got v=%b pc=%h want 1/0", out_valid, out_pc); end
  endtask

  task automatic test_misaligned();
    out_ready = 1'b1;
    redirect(64'h42);
    total++; if (fault !== 1'b1 || fault_pc !== 64'h42) begin bad++; $display("FAIL mis_fault: got %b/%h want 1/42", fault, fault_pc); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (out_valid !== 1'b0 || imem_addr !== 64'h42) begin bad++; $display("FAIL mis_idle[%0d]: got v=%b addr=%h want 0/42", k, out_valid, imem_addr); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    redirect(64'd1016);
    repeat (3) tick();
    total++; if (out_valid !== 1'b1 || fault !== 1'b1 || fault_pc !== 64'd1024) begin
      bad++; $display("FAIL ar_pre: got v=%b f=%b fpc=%h want 1/1/400", out_valid, fault, fault_pc);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0 || fault !== 1'b0 || imem_addr !== 64'h0) begin
      bad++; $display("FAIL ar_clear: got v=%b f=%b addr=%h want 0/0/0", out_valid, fault, imem_addr);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== rom[0]) begin
      bad++; $display("FAIL ar_restart: got v=%b pc=%h want 1/0", out_valid, out_pc);
    end
  endtask

  task automatic test_random();
    redirect(64'h0);
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(19) == 0) begin
        redirect_valid = 1'b1;
        case ($urandom_range(3))
          0:       redirect_pc = 64'($urandom_range(255)) * 64'd4;
          1:       redirect_pc = 64'd1008 + 64'($urandom_range(3)) * 64'd4;
          2:       redirect_pc = 64'($urandom_range(255)) * 64'd4 + 64'($urandom_range(3, 1));
          default: redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        endcase
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
      total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        total++; if (out_pc !== q[0] || out_instr !== rom[q[0][9:2]]) begin
          bad++; $display("FAIL rnd_head[%0d]: got %h/%h want %h/%h", i, out_pc, out_instr, q[0], rom[q[0][9:2]]);
        end
      end
      total++; if (fault !== m_fault || imem_addr !== m_nf) begin
        bad++; $display("FAIL rnd_state[%0d]: got f=%b addr=%h want %b/%h", i, fault, imem_addr, m_fault, m_nf);
      end
      if (m_fault) begin
        total++; if (fault_pc !== m_fpc) begin bad++; $display("FAIL rnd_fpc[%0d]: got %h want %h", i, fault_pc, m_fpc); end
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_end_of_mem();
    test_misaligned();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
